db15_pad_tx: RTL and testbench
==============================

# db15_pad_tx

Device-side responder for the DB15 serial joystick link. It emulates the pair of parallel-in/serial-out shift registers in a DB15 pad adapter. On a host load strobe it snapshots both players' button words, then presents one bit per host clock on the serial data line, active-low on the wire. It sits behind the UserIO port in test and adapter builds, where it drives the host-side DB15 receiver in loopback benches and lets an FPGA act as a DB15 pad.

## Interface
Parameters:
- NBITS, 12: button bits per player; frame length is 2*NBITS.
- FILT, 3: consecutive equal synchronized samples required to accept a level change on joy_clk/joy_load (1..7).

Ports:
- clk_sys  in  1  system clock, 40–50 MHz; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- joystick1  in  NBITS  player-1 buttons, active-high, bit0 = R; order R,L,D,U,A,B,C,X,Y,Z,Start,Mode.
- joystick2  in  NBITS  player-2 buttons, same layout.
- joy_clk  in  1  host shift clock, asynchronous; a rising edge advances one bit.
- joy_load  in  1  host load strobe, asynchronous, active-low; low = parallel load.
- joy_data  out  1  serial data to host, active-low (pressed = 0).
- frame_done  out  1  one-cycle pulse when the last frame bit has been shifted past.
- bit_idx  out  $clog2(2*NBITS+1)  index of the bit currently on joy_data; 2*NBITS = past end.

## Operation
- Input conditioning: joy_clk and joy_load each pass a 2-FF synchronizer, then a filter. The filtered level changes only after FILT consecutive identical samples. Edge detection runs on the filtered levels.
- Frame register: 2*NBITS wide, holding {~joystick2, ~joystick1}; joystick1 bit0 is shifted out first. Serial fill value is 1, the idle/pull-up level.
- States:
  - IDLE: waiting for a load. Frame register is held; joy_data = 1; bit_idx = 2*NBITS.
  - LOAD: entered while filtered load is low, from any state. Every cycle, frame reloads from the live inputs, bit_idx = 0, joy_data = ~joystick1[0]. Clock edges are ignored.
  - SHIFT: entered on the filtered load rising edge. Each filtered joy_clk rising edge shifts the frame by one and increments bit_idx. On the edge that makes bit_idx = 2*NBITS, frame_done pulses and the state returns to IDLE.
- Extra clock edges in IDLE are ignored; joy_data stays 1.
- Load falling mid-frame aborts the frame and forces LOAD; frame_done does not pulse.
- Simultaneous filtered load-rise and clk-rise in the same cycle: the load rise is taken first; the clk edge is discarded.
- joystick inputs changing during SHIFT do not affect the frame in flight.
- joy_data is registered directly from frame[0], or forced to 1 in IDLE. No combinational path from the inputs.

## Timing
- Reset (reset_n = 0 at a clk_sys edge):
  - state = IDLE, frame = all 1, joy_data = 1, frame_done = 0, bit_idx = 2*NBITS.
  - Synchronizers and filters are preset to 1, which is the idle level.
- Reset mid-frame abandons the frame. The first cycle after release shows the IDLE values.
- Pin-to-output latency: a pin edge reaches joy_data in 2 sync + FILT filter + 1 register = FILT+3 cycles (6 at default), i.e. 150 ns at 40 MHz.
- Host constraint: joy_clk and joy_load high/low times ≥ (FILT+4) clk_sys periods. Pulses shorter than FILT cycles are rejected entirely.
- frame_done is asserted for exactly one cycle, FILT+3 cycles after the final joy_clk rising pin edge.
- bit_idx updates in the same cycle as joy_data.

## Structure
- Shared package db15_pkg:
  - localparam DB15_NBITS = 12.
  - Button-index constants (BTN_R … BTN_MODE).
  - enum db15_tx_state_t {IDLE, LOAD, SHIFT}.
- One sub-module: db15_in_filter (2-FF sync + FILT-sample glitch filter + rise/fall strobes), instantiated twice.
- The top holds the FSM, frame register and counter.

## Test plan
- Basic frame: joystick1 = 12'h001, joystick2 = 12'h800. Pulse load low, then 24 clk rises → serial bits 0,1×22,0 (bit0 and bit23 low, all others high), then frame_done pulses once.
- Extra clocks: after a full frame, issue 4 more clk rises → joy_data stays 1, no frame_done, bit_idx holds 24.
- Glitch rejection: a 2-cycle low pulse on joy_clk with FILT = 3 → no shift, bit_idx unchanged. A (FILT+4)-cycle pulse shifts exactly once.
- Abort: load low after 10 shifts → bit_idx returns to 0, joy_data = ~joystick1[0] within 6 cycles, no frame_done.
- Live load: change joystick1 from 0 to 12'h010 while load is held low → joy_data follows bit0 throughout. Bit4 reads 0 after release and 4 shifts.
- Reset mid-frame: assert reset_n = 0 for 1 cycle at bit 7 → the next cycle shows joy_data = 1, bit_idx = 24, IDLE. Later clk edges are ignored until a load.

Source files
------------

// File: rtl/db15_pkg.sv
// Shared definitions for the DB15 serial joystick link: frame geometry,
// button bit positions and the pad-side transmitter state encoding.
package db15_pkg;

    localparam int DB15_NBITS = 12;

    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_X     = 7;
    localparam int BTN_Y     = 8;
    localparam int BTN_Z     = 9;
    localparam int BTN_START = 10;
    localparam int BTN_MODE  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } db15_tx_state_t;

endpackage

// File: rtl/db15_in_filter.sv
// Conditions one asynchronous host pin: 2-FF synchronizer, then a glitch filter
// that only accepts a new level after FILT consecutive identical samples.
module db15_in_filter #(
    parameter int FILT = 3
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic toggle
);

    localparam int CW = (FILT < 2) ? 1 : $clog2(FILT);

    logic [1:0]    sync_r;
    logic          level_r;
    logic          toggle_r;
    logic [CW-1:0] cnt_r;

    // Synchronize the pin and count how long it has disagreed with the accepted level.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync_r   <= 2'b11;
            level_r  <= 1'b1;
            toggle_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else begin
            sync_r   <= {sync_r[0], pin};
            toggle_r <= 1'b0;
            if (sync_r[1] != level_r) begin
                // The FILT-th disagreeing sample flips the level; the strobe rides along with it.
                if (cnt_r == CW'(FILT - 1)) begin
                    level_r  <= sync_r[1];
                    toggle_r <= 1'b1;
                    cnt_r    <= {CW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= {CW{1'b0}};
            end
        end
    end

    assign level  = level_r;
    assign toggle = toggle_r;

endmodule

// File: rtl/db15_pad_tx.sv
// DB15 pad emulator: snapshots both players' buttons on the host load strobe and
// shifts them out one bit per host clock, active-low, player 1 bit 0 first.
module db15_pad_tx
    import db15_pkg::*;
#(
    parameter int NBITS = DB15_NBITS,
    parameter int FILT  = 3
) (
    input  logic                             clk_sys,
    input  logic                             reset_n,
    input  logic [NBITS-1:0]                 joystick1,
    input  logic [NBITS-1:0]                 joystick2,
    input  logic                             joy_clk,
    input  logic                             joy_load,
    output logic                             joy_data,
    output logic                             frame_done,
    output logic [$clog2(2*NBITS+1)-1:0]     bit_idx
);

    localparam int FW = 2 * NBITS;
    localparam int IW = $clog2(2 * NBITS + 1);
    localparam logic [IW-1:0] IDX_END  = IW'(FW);
    localparam logic [IW-1:0] IDX_LAST = IW'(FW - 1);

    db15_tx_state_t state_r, state_d;
    logic [FW-1:0]  frame_r, frame_d;
    logic [IW-1:0]  idx_r, idx_d;
    logic           data_r, data_d;
    logic           done_r, done_d;

    logic clk_lvl_s, clk_tgl_s, load_lvl_s, load_tgl_s;
    logic clk_rise_s, load_rise_s, last_bit_s;

    db15_in_filter #(.FILT(FILT)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .pin     (joy_clk),
        .level   (clk_lvl_s),
        .toggle  (clk_tgl_s)
    );

    db15_in_filter #(.FILT(FILT)) u_load_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .pin     (joy_load),
        .level   (load_lvl_s),
        .toggle  (load_tgl_s)
    );

    assign clk_rise_s  = clk_tgl_s & clk_lvl_s;
    assign load_rise_s = load_tgl_s & load_lvl_s;
    assign last_bit_s  = (idx_r == IDX_LAST);

    // State register.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_d;
        end
    end

    // Next state: a low load level wins over everything, including clock edges.
    always_comb begin
        state_d = state_r;
        if (!load_lvl_s) begin
            state_d = LOAD;
        end else begin
            case (state_r)
                IDLE:    state_d = IDLE;
                LOAD:    if (load_rise_s) state_d = SHIFT; else state_d = LOAD;
                SHIFT:   if (clk_rise_s && last_bit_s) state_d = IDLE; else state_d = SHIFT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next frame/index/outputs; joy_data takes the bit the frame will hold after this edge.
    always_comb begin
        frame_d = frame_r;
        idx_d   = idx_r;
        done_d  = 1'b0;
        if (state_d == LOAD) begin
            frame_d = {~joystick2, ~joystick1};
            idx_d   = {IW{1'b0}};
        end else if ((state_r == SHIFT) && clk_rise_s) begin
            frame_d = {1'b1, frame_r[FW-1:1]};
            idx_d   = idx_r + IW'(1);
            done_d  = last_bit_s;
        end else begin
            frame_d = frame_r;
        end
        if (state_d == IDLE) begin
            data_d = 1'b1;
        end else begin
            data_d = frame_d[BTN_R];
        end
    end

    // Frame, counter and registered outputs.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            frame_r <= {FW{1'b1}};
            idx_r   <= IDX_END;
            data_r  <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            frame_r <= frame_d;
            idx_r   <= idx_d;
            data_r  <= data_d;
            done_r  <= done_d;
        end
    end

    assign joy_data   = data_r;
    assign frame_done = done_r;
    assign bit_idx    = idx_r;

endmodule

// File: tb/tb_db15_pad_tx.sv
// Bench for db15_pad_tx: host-side pin stimulus, an event-level reference model
// of the pad (captured words + bit counter) and a per-cycle output compare.
module tb_db15_pad_tx;

    localparam int NB   = db15_pkg::DB15_NBITS;
    localparam int FILT = 3;
    localparam int FW   = 2 * NB;
    localparam int LAT  = FILT + 3;
    localparam int IW   = $clog2(2 * NB + 1);

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic [NB-1:0] j1, j2;
    logic          joy_clk, joy_load;
    logic          joy_data, frame_done;
    logic [IW-1:0] bit_idx;

    db15_pad_tx #(.NBITS(NB), .FILT(FILT)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .joystick1  (j1),
        .joystick2  (j2),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_data   (joy_data),
        .frame_done (frame_done),
        .bit_idx    (bit_idx)
    );

    always #10 clk_sys = ~clk_sys;

    typedef struct {
        int due;
        bit is_load;
        bit val;
    } ev_t;

    ev_t           evq[$];
    int            cyc = 0;
    int            m_mode = 0;     // 0 idle, 1 load, 2 shift
    int            m_n = FW;
    bit            m_done = 1'b0;
    bit            m_valid = 1'b0;
    logic [NB-1:0] cap1 = '0, cap2 = '0;
    int            done_seen = 0;
    int            vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    function automatic logic exp_bit(input int n);
        if (n < NB) return ~cap1[n];
        return ~cap2[n-NB];
    endfunction

    // Reference model: pin edges take effect a fixed LAT cycles after they are driven.
    always @(posedge clk_sys) begin : model_p
        bit lrise, lfall, crise;
        ev_t e;
        cyc++;
        if (!reset_n) begin
            m_mode = 0; m_n = FW; m_done = 1'b0; m_valid = 1'b1;
            evq.delete();
        end else begin
            m_done = 1'b0; lrise = 1'b0; lfall = 1'b0; crise = 1'b0;
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                e = evq.pop_front();
                if (e.is_load) begin
                    if (e.val) lrise = 1'b1; else lfall = 1'b1;
                end else if (e.val) begin
                    crise = 1'b1;
                end
            end
            if (lfall) m_mode = 1;
            if (lrise) begin m_mode = 2; m_n = 0; end
            if (crise && !lrise && m_mode == 2) begin
                m_n++;
                if (m_n == FW) begin m_done = 1'b1; m_mode = 0; end
            end
            if (m_mode == 1) begin cap1 = j1; cap2 = j2; end
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk_sys) begin
        if (m_valid) begin
            logic xd;
            int   xi;
            xd = (m_mode == 0) ? 1'b1 : (m_mode == 1) ? ~cap1[0] : exp_bit(m_n);
            xi = (m_mode == 0) ? FW : (m_mode == 1) ? 0 : m_n;
            check("joy_data", 32'(joy_data), 32'(xd));
            check("bit_idx", 32'(bit_idx), 32'(xi));
            check("frame_done", 32'(frame_done), 32'(m_done));
            if (frame_done) done_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic set_load(input bit v);
        ev_t e;
        joy_load = v;
        e.due = cyc + LAT; e.is_load = 1'b1; e.val = v;
        evq.push_back(e);
    endtask

    task automatic set_clk(input bit v);
        ev_t e;
        joy_clk = v;
        e.due = cyc + LAT; e.is_load = 1'b0; e.val = v;
        evq.push_back(e);
    endtask

    task automatic clk_pulse(input int lo, input int hi);
        set_clk(1'b0); tick(lo);
        set_clk(1'b1); tick(hi);
    endtask

    task automatic glitch_low(input int w);
        joy_clk = 1'b0; tick(w);
        joy_clk = 1'b1; tick(FILT + 4);
    endtask

    task automatic load_frame(input logic [NB-1:0] a, input logic [NB-1:0] b);
        j1 = a; j2 = b;
        set_load(1'b0); tick(8);
        set_load(1'b1); tick(8);
    endtask

    initial begin
        int d0;
        reset_n = 1'b0; joy_clk = 1'b1; joy_load = 1'b1; j1 = '0; j2 = '0;
        tick(3);
        check("reset_data", 32'(joy_data), 32'd1);
        check("reset_idx", 32'(bit_idx), 32'd24);
        check("reset_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        tick(4);

        // Basic frame: only bit0 and bit23 pressed.
        load_frame(12'h001, 12'h800);
        d0 = done_seen;
        for (int i = 0; i < FW; i++) begin
            check("basic_bit", 32'(joy_data), (i == 0 || i == 23) ? 32'd0 : 32'd1);
            clk_pulse(8, 8);
        end
        check("basic_done_cnt", 32'(done_seen - d0), 32'd1);
        check("basic_end_idx", 32'(bit_idx), 32'd24);

        // Extra clocks after the frame are ignored.
        for (int i = 0; i < 4; i++) clk_pulse(8, 8);
        check("extra_done_cnt", 32'(done_seen - d0), 32'd1);
        check("extra_idx", 32'(bit_idx), 32'd24);
        check("extra_data", 32'(joy_data), 32'd1);

        // Glitch rejection, then a minimum-width pulse shifts once.
        load_frame(12'h5a5, 12'h3c3);
        glitch_low(2);
        glitch_low(FILT - 1);
        check("glitch_idx", 32'(bit_idx), 32'd0);
        clk_pulse(FILT + 4, FILT + 4);
        check("minpulse_idx", 32'(bit_idx), 32'd1);

        // Abort after 10 shifts.
        for (int i = 1; i < 10; i++) clk_pulse(8, 8);
        check("abort_pre_idx", 32'(bit_idx), 32'd10);
        d0 = done_seen;
        set_load(1'b0); tick(LAT);
        check("abort_idx", 32'(bit_idx), 32'd0);
        check("abort_data", 32'(joy_data), 32'd0);

        // Live load while the strobe is held low.
        j1 = 12'h000; tick(1);
        check("live_data0", 32'(joy_data), 32'd1);
        j1 = 12'h001; tick(1);
        check("live_data1", 32'(joy_data), 32'd0);
        j1 = 12'h010; tick(1);
        check("live_data2", 32'(joy_data), 32'd1);
        set_load(1'b1); tick(8);
        for (int i = 0; i < 4; i++) clk_pulse(8, 8);
        check("live_bit4", 32'(joy_data), 32'd0);
        check("live_idx4", 32'(bit_idx), 32'd4);
        check("abort_no_done", 32'(done_seen - d0), 32'd0);

        // Reset in the middle of a frame.
        load_frame(12'hfff, 12'h000);
        for (int i = 0; i < 7; i++) clk_pulse(8, 8);
        check("rst_pre_idx", 32'(bit_idx), 32'd7);
        reset_n = 1'b0; tick(1);
        check("rst_data", 32'(joy_data), 32'd1);
        check("rst_idx", 32'(bit_idx), 32'd24);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) clk_pulse(8, 8);
        check("rst_ignored_idx", 32'(bit_idx), 32'd24);

        // Load rise and clock rise in the same cycle: clock edge discarded.
        j1 = 12'h002; j2 = 12'h000;
        set_load(1'b0); tick(8);
        set_clk(1'b0); tick(8);
        set_load(1'b1); set_clk(1'b1); tick(8);
        check("simul_idx", 32'(bit_idx), 32'd0);
        clk_pulse(8, 8);
        check("simul_bit1", 32'(joy_data), 32'd0);

        // Randomized frames, aborts, glitches and button changes mid-frame.
        for (int f = 0; f < 30; f++) begin
            int nsh, abort_at;
            j1 = NB'($urandom); j2 = NB'($urandom);
            set_load(1'b0); tick($urandom_range(7, 12));
            if ($urandom_range(0, 1) == 1) begin
                j1 = NB'($urandom); tick($urandom_range(1, 4));
            end
            set_load(1'b1); tick($urandom_range(7, 12));
            nsh = $urandom_range(0, 30);
            abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 23) : -1;
            for (int s = 0; s < nsh; s++) begin
                if (s == abort_at) begin
                    set_load(1'b0); tick($urandom_range(7, 12));
                    set_load(1'b1); tick($urandom_range(7, 12));
                end
                if ($urandom_range(0, 5) == 0) j1 = NB'($urandom);
                if ($urandom_range(0, 5) == 0) j2 = NB'($urandom);
                if ($urandom_range(0, 7) == 0) glitch_low($urandom_range(1, FILT - 1));
                clk_pulse($urandom_range(7, 11), $urandom_range(7, 11));
            end
            tick(LAT + 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
